// File: rtl/if_id_stage.sv
// Instruction-fetch stage: PC register, IROM addressing and the IF/ID pipeline register.
// Per-edge action priority is REDIR > STALL_D > STALL_J > RUN; stall/redirect counters saturate.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_jump,
  input  logic             stall_data,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic [31:0]      irom_inst,
  output logic [31:0]      irom_addr,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic [31:0]      id_inst,
  output logic             id_valid,
  output logic [1:0]       fetch_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_STALL_J = 2'd1;
  localparam logic [1:0] ST_STALL_D = 2'd2;
  localparam logic [1:0] ST_REDIR   = 2'd3;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_pc4_q, id_pc4_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic             id_valid_q, id_valid_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  // Next-state: choose this edge's action, then apply its PC / IF-ID / counter effects.
  always_comb begin
    state_d     = ST_RUN;
    pc_d        = pc_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;

    if (redirect_valid) begin
      state_d    = ST_REDIR;
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      if (redir_cnt_q != {CNT_W{1'b1}}) redir_cnt_d = redir_cnt_q + CNT_W'(1);
    end else if (stall_data) begin
      state_d = ST_STALL_D;
      if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (stall_jump) begin
      state_d    = ST_STALL_J;
      id_inst_d  = NOP_INST;
      id_valid_d = 1'b0;
      if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      state_d    = ST_RUN;
      pc_d       = pc_q + 32'd4;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_q + 32'd4;
      id_inst_d  = irom_inst;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      id_pc_q     <= 32'd0;
      id_pc4_q    <= 32'd0;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign irom_addr   = pc_q;
  assign id_pc       = id_pc_q;
  assign id_pc4      = id_pc4_q;
  assign id_inst     = id_inst_q;
  assign id_valid    = id_valid_q;
  assign fetch_state = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign redir_cnt   = redir_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: a reference model pushes expected outputs per edge,
// each test task pops and compares after the edge, plus fixed-value spot checks.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_jump = 1'b0;
  logic        stall_data = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] irom_inst;
  logic [31:0] irom_addr, id_pc, id_pc4, id_inst;
  logic        id_valid;
  logic [1:0]  fetch_state;
  logic [15:0] stall_cnt, redir_cnt;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        valid;
    logic [1:0]  st;
    logic [15:0] scnt;
    logic [15:0] rcnt;
  } obs_t;

  obs_t sb_q[$];
  obs_t exp_o, got_o;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_inst;
  logic        m_valid;
  logic [1:0]  m_state;
  logic [15:0] m_scnt, m_rcnt;

  if_id_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_jump(stall_jump), .stall_data(stall_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .irom_inst(irom_inst),
    .irom_addr(irom_addr), .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst),
    .id_valid(id_valid), .fetch_state(fetch_state), .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] irom_model(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign irom_inst = irom_model(irom_addr);

  function automatic obs_t sample();
    return {irom_addr, id_pc, id_pc4, id_inst, id_valid, fetch_state, stall_cnt, redir_cnt};
  endfunction

  // Assert reset asynchronously, reset the model, release just after a posedge.
  task automatic do_reset();
    stall_jump = 0; stall_data = 0; redirect_valid = 0; redirect_pc = 0;
    rst = 1'b1;
    m_pc = 32'd0; m_id_pc = 0; m_id_pc4 = 0; m_inst = NOP; m_valid = 0;
    m_state = 0; m_scnt = 0; m_rcnt = 0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drive one edge's requests on the negedge, push the model's prediction, land #1 after posedge.
  task automatic drive(input logic sj, input logic sd, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    stall_jump = sj; stall_data = sd; redirect_valid = rv; redirect_pc = rpc;
    if (rv) begin
      m_state = 2'd3; m_pc = {rpc[31:2], 2'b00}; m_inst = NOP; m_valid = 0;
      if (m_rcnt != 16'hFFFF) m_rcnt = m_rcnt + 16'd1;
    end else if (sd) begin
      m_state = 2'd2;
      if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
    end else if (sj) begin
      m_state = 2'd1; m_inst = NOP; m_valid = 0;
      if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
    end else begin
      m_state = 2'd0; m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4;
      m_inst = irom_model(m_pc); m_valid = 1; m_pc = m_pc + 32'd4;
    end
    sb_q.push_back({m_pc, m_id_pc, m_id_pc4, m_inst, m_valid, m_state, m_scnt, m_rcnt});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    got_o = sample();
    exp_o = {32'h0, 32'h0, 32'h0, NOP, 1'b0, 2'd0, 16'h0, 16'h0};
    n_cmp++;
    if (got_o !== exp_o) begin
      n_err++; $display("FAIL reset_async: got %h expected %h", got_o, exp_o);
    end
    do_reset();
    n_cmp++;
    if (irom_addr !== 32'h0 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release: irom_addr %h id_valid %b expected 0/0", irom_addr, id_valid);
    end
  endtask

  task automatic test_run();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0);
      exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
      if (got_o !== exp_o) begin
        n_err++; $display("FAIL run[%0d]: got %h expected %h", i, got_o, exp_o);
      end
      n_cmp++;
      if (id_inst !== 32'h1000_0000 + i || id_pc !== 32'(i * 4) || id_valid !== 1'b1) begin
        n_err++; $display("FAIL run_seq[%0d]: inst %h pc %h v %b", i, id_inst, id_pc, id_valid);
      end
    end
    n_cmp++;
    if (irom_addr !== 32'h10) begin
      n_err++; $display("FAIL run_addr: got %h expected 00000010", irom_addr);
    end
  endtask

  task automatic test_stall_jump();
    logic sj;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sj = (i == 3 || i == 4);
      drive(sj, 0, 0, 0);
      exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
      if (got_o !== exp_o) begin
        n_err++; $display("FAIL stall_jump[%0d]: got %h expected %h", i, got_o, exp_o);
      end
      if (sj) begin
        n_cmp++;
        if (id_inst !== NOP || id_valid !== 1'b0 || irom_addr !== 32'hC || fetch_state !== 2'd1) begin
          n_err++; $display("FAIL sj_bubble[%0d]: inst %h v %b addr %h st %0d", i, id_inst, id_valid, irom_addr, fetch_state);
        end
      end
    end
    n_cmp++;
    if (stall_cnt !== 16'd2 || id_inst !== 32'h1000_0003 || id_pc !== 32'hC) begin
      n_err++; $display("FAIL sj_resume: cnt %0d inst %h pc %h expected 2/10000003/c", stall_cnt, id_inst, id_pc);
    end
  endtask

  task automatic test_stall_data();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      // middle stall edge also raises stall_jump: still one STALL_D increment
      drive(i == 3, i >= 2, 0, 0);
      exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
      if (got_o !== exp_o) begin
        n_err++; $display("FAIL stall_data[%0d]: got %h expected %h", i, got_o, exp_o);
      end
    end
    n_cmp++;
    if (id_pc !== 32'h4 || id_inst !== 32'h1000_0001 || irom_addr !== 32'h8
        || stall_cnt !== 16'd3 || fetch_state !== 2'd2 || id_valid !== 1'b1) begin
      n_err++; $display("FAIL sd_frozen: pc %h inst %h addr %h cnt %0d st %0d", id_pc, id_inst, irom_addr, stall_cnt, fetch_state);
    end
  endtask

  task automatic test_redirect();
    logic [15:0] scnt0;
    do_reset();
    drive(0, 0, 0, 0);
    void'(sb_q.pop_front());
    drive(0, 1, 0, 0);
    void'(sb_q.pop_front());
    scnt0 = stall_cnt;
    drive(1, 1, 1, 32'h0000_0203);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o) begin
      n_err++; $display("FAIL redirect: got %h expected %h", got_o, exp_o);
    end
    n_cmp++;
    if (irom_addr !== 32'h200 || id_valid !== 1'b0 || redir_cnt !== 16'd1 || stall_cnt !== 16'd1 || fetch_state !== 2'd3) begin
      n_err++; $display("FAIL redir_state: addr %h v %b rcnt %0d scnt %0d (was %0d)", irom_addr, id_valid, redir_cnt, stall_cnt, scnt0);
    end
    drive(0, 0, 0, 0);
    exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
    if (got_o !== exp_o || id_pc !== 32'h200 || id_inst !== 32'h1000_0080) begin
      n_err++; $display("FAIL redir_target: got %h expected %h", got_o, exp_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 0, 1, 32'hFFFF_FFF8);
    void'(sb_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
      if (got_o !== exp_o) begin
        n_err++; $display("FAIL wrap[%0d]: got %h expected %h", i, got_o, exp_o);
      end
      if (i == 1) begin
        n_cmp++;
        if (id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 || irom_addr !== 32'h0) begin
          n_err++; $display("FAIL wrap_edge: pc %h pc4 %h addr %h", id_pc, id_pc4, irom_addr);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      drive(0, 1, 0, 0);
      exp_o = sb_q.pop_front(); got_o = sample(); n_cmp++;
      if (got_o !== exp_o) begin
        n_err++; $display("FAIL sat[%0d]: got %h expected %h", i, got_o, exp_o);
      end
    end
    n_cmp++;
    if (stall_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_cnt: got %h expected ffff", stall_cnt);
    end
    #2 rst = 1'b1;
    #1;
    got_o = sample();
    exp_o = {32'h0, 32'h0, 32'h0, NOP, 1'b0, 2'd0, 16'h0, 16'h0};
    n_cmp++;
    if (got_o !== exp_o) begin
      n_err++; $display("FAIL mid_reset: got %h expected %h", got_o, exp_o);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall_jump();
    test_stall_data();
    test_redirect();
    test_wrap();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
